uart_tx_fifo: RTL and testbench

Buffered UART transmitter, 8N1 framing, LSB first. The host side is the byte-write interface a client such as the echo loop drives: a one-cycle `uart_tx_start` pulse with `uart_tx_data_in`. Bytes queue in an internal FIFO and are serialised on `uart_tx_pin` at a runtime-programmable baud divisor. It sits between host logic and the board TX pin, and is the transmit counterpart of the team's RX/FIFO path.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 60 ++++++
 rtl/uart_tx_fifo.sv | 155 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the buffered UART transmitter.
// Imported by the TX top level.
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = 10;
  localparam int UART_DIV_W      = 16;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  function automatic logic [UART_DIV_W-1:0] eff_div(
    input logic [UART_DIV_W-1:0] div
  );
    return (div == '0) ? UART_DIV_W'(1) : div;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
// A write while full is ignored even if a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign dout    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter, LSB first, runtime baud divisor.
// Frames run back to back while the queue holds data.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [15:0]                  baud_div,
  input  logic                         uart_tx_start,
  input  logic [7:0]                   uart_tx_data_in,
  output logic                         uart_tx_pin,
  output logic                         uart_tx_full,
  output logic [$clog2(FIFO_DEPTH):0]  uart_tx_level,
  output logic                         uart_tx_busy,
  output logic                         uart_tx_overflow
);

  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic [7:0]  fifo_dout;
  logic        fifo_empty;
  logic        fifo_full;
  logic        pop;

  tx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] div_q, div_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic        pin_q, pin_d;
  logic        ovf_q;
  logic        expired;
  logic [15:0] div_now;

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (uart_tx_start),
    .pop   (pop),
    .din   (uart_tx_data_in),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (uart_tx_level)
  );

  assign expired = (cnt_q == '0);
  assign div_now = eff_div(baud_div);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    pin_d   = pin_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        pin_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          sh_d    = fifo_dout;
          div_d   = div_now;
          cnt_d   = div_now - 16'd1;
          pin_d   = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (expired) begin
          pin_d   = sh_q[0];
          sh_d    = {1'b0, sh_q[7:1]};
          bit_d   = '0;
          cnt_d   = div_q - 16'd1;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (expired) begin
          cnt_d = div_q - 16'd1;
          if (bit_q == LAST_BIT) begin
            pin_d   = 1'b1;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
            pin_d = sh_q[0];
            sh_d  = {1'b0, sh_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      STOP: begin
        if (!expired) begin
          cnt_d = cnt_q - 16'd1;
        end else if (!fifo_empty) begin
          // Chain straight into the next start bit, no idle gap.
          pop     = 1'b1;
          sh_d    = fifo_dout;
          div_d   = div_now;
          cnt_d   = div_now - 16'd1;
          pin_d   = 1'b0;
          state_d = START;
        end else begin
          pin_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        pin_d   = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= 16'd1;
      bit_q   <= '0;
      sh_q    <= '0;
      pin_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      pin_q   <= pin_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (uart_tx_start && fifo_full) begin
      ovf_q <= 1'b1;
    end
  end

  assign uart_tx_pin      = pin_q;
  assign uart_tx_full     = fifo_full;
  assign uart_tx_overflow = ovf_q;
  assign uart_tx_busy     = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: frame-timing model checked every cycle,
// plus literal waveform and status expectations.
module tb_uart_tx_fifo;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] baud_div = 16'd4;
  logic        uart_tx_start = 1'b0;
  logic [7:0]  uart_tx_data_in = 8'h00;
  logic        uart_tx_pin;
  logic        uart_tx_full;
  logic [5:0]  uart_tx_level;
  logic        uart_tx_busy;
  logic        uart_tx_overflow;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  uart_tx_fifo #(.FIFO_DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .baud_div         (baud_div),
    .uart_tx_start    (uart_tx_start),
    .uart_tx_data_in  (uart_tx_data_in),
    .uart_tx_pin      (uart_tx_pin),
    .uart_tx_full     (uart_tx_full),
    .uart_tx_level    (uart_tx_level),
    .uart_tx_busy     (uart_tx_busy),
    .uart_tx_overflow (uart_tx_overflow)
  );

  always #5 clk = ~clk;

  // Model: queue of pending bytes plus the frame on the wire, timed
  // in clocks since its start bit began.
  logic [7:0] mq[$];
  bit         in_frame = 1'b0;
  bit         m_ovf = 1'b0;
  int         fr_t = 0;
  int         fr_div = 1;
  logic [7:0] fr_byte = 8'h00;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mq.delete();
        in_frame = 1'b0;
        m_ovf    = 1'b0;
        fr_t     = 0;
      end else begin
        bit full_b;
        bit empty_b;
        bit go;
        full_b  = (mq.size() == DEPTH);
        empty_b = (mq.size() == 0);
        go      = 1'b0;
        if (in_frame) begin
          fr_t++;
          if (fr_t == 10 * fr_div) begin
            in_frame = 1'b0;
            go       = !empty_b;
          end
        end else begin
          go = !empty_b;
        end
        if (go) begin
          fr_byte  = mq.pop_front();
          fr_div   = (baud_div == 16'd0) ? 1 : int'(baud_div);
          fr_t     = 0;
          in_frame = 1'b1;
        end
        if (uart_tx_start) begin
          if (full_b) m_ovf = 1'b1;
          else mq.push_back(uart_tx_data_in);
        end
      end
    end
  end

  function automatic logic m_pin();
    int b;
    if (!in_frame) return 1'b1;
    b = fr_t / fr_div;
    if (b == 0) return 1'b0;
    if (b >= 9) return 1'b1;
    return fr_byte[b-1];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("pin", 32'(uart_tx_pin), 32'(m_pin()));
      chk("level", 32'(uart_tx_level), 32'(mq.size()));
      chk("full", 32'(uart_tx_full), 32'(mq.size() == DEPTH));
      chk("busy", 32'(uart_tx_busy), 32'(in_frame || mq.size() != 0));
      chk("overflow", 32'(uart_tx_overflow), 32'(m_ovf));
    end
  end

  // Called at a negedge; sets the strobe and returns one negedge later.
  task automatic write_byte(input logic [7:0] b);
    uart_tx_start   = 1'b1;
    uart_tx_data_in = b;
    @(negedge clk);
    uart_tx_start   = 1'b0;
  endtask

  // fb[i] is the pin level during bit i (start..stop); first sample now.
  task automatic capture(input logic [9:0] fb, input int div,
                         input string nm, input int chg_at,
                         input logic [15:0] chg_val);
    for (int i = 0; i < 10 * div; i++) begin
      if (i == chg_at) baud_div = chg_val;
      chk(nm, 32'(uart_tx_pin), 32'(fb[i / div]));
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int n;
    n = 0;
    while (uart_tx_busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(uart_tx_busy), 32'd0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_pin", 32'(uart_tx_pin), 32'd1);
    chk("rst_level", 32'(uart_tx_level), 32'd0);
    chk("rst_busy", 32'(uart_tx_busy), 32'd0);
    chk("rst_full", 32'(uart_tx_full), 32'd0);
    chk("rst_ovf", 32'(uart_tx_overflow), 32'd0);
    rst = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);

    // Single byte 0x55 at 4 clocks per bit
    baud_div = 16'd4;
    write_byte(8'h55);
    chk("lat_pin", 32'(uart_tx_pin), 32'd1);
    chk("lat_busy", 32'(uart_tx_busy), 32'd1);
    @(negedge clk);
    capture(10'b1010101010, 4, "f55", -1, 16'd0);
    chk("f55_busy", 32'(uart_tx_busy), 32'd0);
    chk("f55_level", 32'(uart_tx_level), 32'd0);
    repeat (3) @(negedge clk);

    // Back-to-back 0xA3, 0x0F
    uart_tx_start   = 1'b1;
    uart_tx_data_in = 8'hA3;
    @(negedge clk);
    uart_tx_data_in = 8'h0F;
    @(negedge clk);
    uart_tx_start   = 1'b0;
    capture(10'b1101000110, 4, "fA3", -1, 16'd0);
    capture(10'b1000011110, 4, "f0F", -1, 16'd0);
    chk("b2b_busy", 32'(uart_tx_busy), 32'd0);
    repeat (2) @(negedge clk);

    // Overflow: 34 writes at a slow divisor
    baud_div = 16'd1000;
    for (int i = 0; i < 34; i++) begin
      uart_tx_start   = 1'b1;
      uart_tx_data_in = 8'(i);
      @(negedge clk);
    end
    uart_tx_start = 1'b0;
    chk("ovf_level", 32'(uart_tx_level), 32'd32);
    chk("ovf_full", 32'(uart_tx_full), 32'd1);
    chk("ovf_flag", 32'(uart_tx_overflow), 32'd1);
    baud_div = 16'd1;
    n = 0;
    while (uart_tx_level == 6'd32 && n < 12000) begin
      @(negedge clk);
      n++;
    end
    chk("ovf_pop", 32'(uart_tx_level), 32'd31);
    capture(10'b1000000010, 1, "f01", -1, 16'd0);
    capture(10'b1000000100, 1, "f02", -1, 16'd0);
    wait_idle(400, "ovf_drain");
    @(negedge clk);

    // Divisor 0 behaves as 1
    baud_div = 16'd0;
    write_byte(8'hFF);
    @(negedge clk);
    capture(10'b1111111110, 1, "fFF_d0", -1, 16'd0);
    chk("d0_busy", 32'(uart_tx_busy), 32'd0);
    baud_div = 16'd1;
    write_byte(8'hFF);
    @(negedge clk);
    capture(10'b1111111110, 1, "fFF_d1", -1, 16'd0);
    chk("d1_busy", 32'(uart_tx_busy), 32'd0);
    chk("ovf_sticky", 32'(uart_tx_overflow), 32'd1);
    @(negedge clk);

    // Reset during data bit 3
    baud_div = 16'd8;
    write_byte(8'h00);
    @(negedge clk);
    repeat (34) @(negedge clk);
    chk("pre_rst_pin", 32'(uart_tx_pin), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_pin", 32'(uart_tx_pin), 32'd1);
    chk("mid_rst_level", 32'(uart_tx_level), 32'd0);
    chk("mid_rst_busy", 32'(uart_tx_busy), 32'd0);
    chk("mid_rst_ovf", 32'(uart_tx_overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("post_rst_pin", 32'(uart_tx_pin), 32'd1);
    end

    // Divisor change during the data bits of the first frame
    baud_div = 16'd4;
    uart_tx_start   = 1'b1;
    uart_tx_data_in = 8'h81;
    @(negedge clk);
    @(negedge clk);
    uart_tx_start   = 1'b0;
    capture(10'b1100000010, 4, "f81_d4", 10, 16'd6);
    capture(10'b1100000010, 6, "f81_d6", -1, 16'd0);
    chk("chg_busy", 32'(uart_tx_busy), 32'd0);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
